sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/debounce_bit.sv | 73 +++++++
 rtl/sync_debounce.sv | 57 +++++
 tb/tb_sync_debounce.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad constants, plus defaults and legal ranges for the input
// synchronizer/debouncer that qualifies the keypad column lines.
package keypad_pkg;

  localparam int unsigned KEYPAD_ROWS = 4;
  localparam int unsigned KEYPAD_COLS = 4;

  localparam int unsigned DEB_WIDTH_DEF  = KEYPAD_COLS;
  localparam int unsigned DEB_WIDTH_MIN  = 1;
  localparam int unsigned DEB_WIDTH_MAX  = 32;

  localparam int unsigned DEB_SYNC_DEF   = 2;
  localparam int unsigned DEB_SYNC_MIN   = 2;
  localparam int unsigned DEB_SYNC_MAX   = 4;

  localparam int unsigned DEB_COUNT_DEF  = 4;
  localparam int unsigned DEB_COUNT_MIN  = 1;
  localparam int unsigned DEB_COUNT_MAX  = 65535;

  // True when every debouncer parameter is inside its legal range.
  function automatic bit deb_params_ok(input int unsigned width,
                                       input int unsigned sync_stages,
                                       input int unsigned debounce_count);
    return (width >= DEB_WIDTH_MIN) && (width <= DEB_WIDTH_MAX) &&
           (sync_stages >= DEB_SYNC_MIN) && (sync_stages <= DEB_SYNC_MAX) &&
           (debounce_count >= DEB_COUNT_MIN) && (debounce_count <= DEB_COUNT_MAX);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced channel: synchronizer chain, persistence counter, stable
// level flop and registered rise/fall pulses.
module debounce_bit
  import keypad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEB_SYNC_DEF,
  parameter int unsigned DEBOUNCE_COUNT = DEB_COUNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic async_in,
  output logic sync_out,
  output logic stable_out,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int unsigned CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   mismatch;

  // Mismatch detection and acceptance on the final qualifying tick.
  always_comb begin
    mismatch = sync_q[SYNC_STAGES-1] ^ stable_q;
    accept   = mismatch && tick && (cnt == CNT_LAST);
  end

  // Synchronizer shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // Persistence counter, stable level and one-cycle edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      if (!mismatch) begin
        cnt <= '0;
      end else if (tick) begin
        if (accept) begin
          cnt      <= '0;
          stable_q <= sync_q[SYNC_STAGES-1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      rise_q <= accept &  sync_q[SYNC_STAGES-1];
      fall_q <= accept & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign stable_out = stable_q;
  assign rise       = rise_q;
  assign fall       = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer and debouncer for keypad column inputs.
module sync_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH          = DEB_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES    = DEB_SYNC_DEF,
  parameter int unsigned DEBOUNCE_COUNT = DEB_COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  if (!deb_params_ok(WIDTH, SYNC_STAGES, DEBOUNCE_COUNT)) begin : g_param_check
    $error("sync_debounce: illegal parameters WIDTH=%0d SYNC_STAGES=%0d DEBOUNCE_COUNT=%0d",
           WIDTH, SYNC_STAGES, DEBOUNCE_COUNT);
  end

  logic [WIDTH-1:0] accept_vec;
  logic             any_change_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .async_in  (async_in[i]),
      .sync_out  (sync_out[i]),
      .stable_out(stable_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .accept    (accept_vec[i])
    );
  end

  // any_change is registered from the per-bit accept terms so it lands on
  // the same edge as the registered rise/fall pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |accept_vec;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, stable_out, rise, fall;
  logic         any_change;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [W-1:0] sync;
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [W-1:0] m_sync [SS];
  logic [W-1:0] m_stable, m_rise, m_fall;
  int unsigned  m_cnt [W];

  sync_debounce #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_COUNT(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .async_in(async_in),
    .sync_out(sync_out),
    .stable_out(stable_out),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int unsigned s = 0; s < SS; s++) m_sync[s] = '0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    for (int unsigned i = 0; i < W; i++) m_cnt[i] = 0;
  endtask

  // Entered at a falling edge: drive, predict, wait one rising edge, compare.
  task automatic step(input logic [W-1:0] in, input logic tk);
    exp_t e;
    logic [W-1:0] so;
    exp_t got;
    async_in = in;
    tick     = tk;
    if (reset) begin
      model_clear();
    end else begin
      so = m_sync[SS-1];
      m_rise = '0;
      m_fall = '0;
      for (int unsigned i = 0; i < W; i++) begin
        if (so[i] == m_stable[i]) begin
          m_cnt[i] = 0;
        end else if (tk) begin
          if (m_cnt[i] == DC - 1) begin
            m_stable[i] = so[i];
            m_cnt[i] = 0;
            if (so[i]) m_rise[i] = 1'b1;
            else       m_fall[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      for (int unsigned s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
      m_sync[0] = in;
    end
    e.sync   = m_sync[SS-1];
    e.stable = m_stable;
    e.rise   = m_rise;
    e.fall   = m_fall;
    e.any    = |(m_rise | m_fall);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_val("sync_out",   32'(sync_out),   32'(got.sync));
    check_val("stable_out", 32'(stable_out), 32'(got.stable));
    check_val("rise",       32'(rise),       32'(got.rise));
    check_val("fall",       32'(fall),       32'(got.fall));
    check_val("any_change", 32'(any_change), 32'(got.any));
    @(negedge clk);
  endtask

  // Entered at a falling edge: assert reset mid-cycle, verify outputs clear
  // without a clock edge, hold through two edges, release at a falling edge.
  task automatic do_reset(input logic [W-1:0] in);
    async_in = in;
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_sync",   32'(sync_out),   32'h0);
    check_val("rst_stable", 32'(stable_out), 32'h0);
    check_val("rst_rise",   32'(rise),       32'h0);
    check_val("rst_fall",   32'(fall),       32'h0);
    check_val("rst_any",    32'(any_change), 32'h0);
    model_clear();
    step(in, 1'b1);
    step(in, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seen;
    logic [W-1:0] cur;
    int unsigned  ticks;
    bit           done;

    model_clear();
    @(negedge clk);
    do_reset(4'b0000);

    // Glitch: three cycles high on bit 0 never reaches acceptance.
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b1);
      seen = seen | rise | fall | {3'b0, any_change};
    end
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 1'b1);
      seen = seen | rise | fall | {3'b0, any_change};
    end
    check_val("glitch_pulses", 32'(seen), 32'h0);
    check_val("glitch_stable", 32'(stable_out), 32'h0);

    // Clean step 0000 -> 1010: sync after 2 edges, accepted on edge 6.
    do_reset(4'b0000);
    for (int k = 1; k <= 8; k++) begin
      step(4'b1010, 1'b1);
      if (k == 2) check_val("step_sync_e2", 32'(sync_out), 32'hA);
      if (k == 5) check_val("step_stable_e5", 32'(stable_out), 32'h0);
      if (k == 6) begin
        check_val("step_stable_e6", 32'(stable_out), 32'hA);
        check_val("step_rise_e6",   32'(rise),       32'hA);
        check_val("step_fall_e6",   32'(fall),       32'h0);
        check_val("step_any_e6",    32'(any_change), 32'h1);
      end
      if (k == 7) begin
        check_val("step_rise_e7", 32'(rise),       32'h0);
        check_val("step_any_e7",  32'(any_change), 32'h0);
      end
    end

    // Go to 1111, then simultaneous fall on bits 3 and 0.
    for (int k = 0; k < 8; k++) step(4'b1111, 1'b1);
    check_val("all_ones_stable", 32'(stable_out), 32'hF);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0110, 1'b1);
      if (k == 6) begin
        check_val("fall_fall_e6",   32'(fall),       32'h9);
        check_val("fall_rise_e6",   32'(rise),       32'h0);
        check_val("fall_stable_e6", 32'(stable_out), 32'h6);
      end
    end

    // Tick gating: tick high on every other edge only.
    do_reset(4'b0000);
    ticks = 0;
    done  = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      logic tk;
      tk = (k % 2 == 0);
      cur = m_sync[SS-1];
      if (cur[2] && tk && !done) ticks++;
      step(4'b0100, tk);
      if (!done && stable_out[2]) begin
        check_val("gate_ticks", 32'(ticks), 32'd4);
        done = 1'b1;
      end
    end
    if (!done) check_val("gate_timeout", 32'(stable_out), 32'h4);

    // Reset mid-count: two counted ticks then reset; full latency after release.
    do_reset(4'b0000);
    for (int k = 0; k < 4; k++) step(4'b1000, 1'b1);
    do_reset(4'b1000);
    for (int k = 1; k <= 7; k++) begin
      step(4'b1000, 1'b1);
      if (k == 5) check_val("rmc_stable_e5", 32'(stable_out), 32'h0);
      if (k == 6) begin
        check_val("rmc_stable_e6", 32'(stable_out), 32'h8);
        check_val("rmc_rise_e6",   32'(rise),       32'h8);
      end
    end

    // Random traffic with sparse level changes and random tick.
    cur = 4'b1000;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) cur = W'($urandom_range(0, 15));
      step(cur, ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
